// File: rtl/vedic_arb_pkg.sv
// Shared types and widths for the vedic multiplier arbiter slice.
// Optional statistics are enabled with VEDIC_ARB_STATS_EN.
package vedic_arb_pkg;

  localparam int MUL_W = 3;
  localparam int ANS_W = 6;

  typedef logic [MUL_W-1:0] operand_t;
  typedef logic [ANS_W-1:0] ans_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/vedic_mul_arbiter_if.sv
// Request/response bus between the operand producers, the arbiter and the product consumer.
interface vedic_mul_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);

  logic [NREQ-1:0]                      req_valid;
  logic [NREQ*vedic_arb_pkg::MUL_W-1:0] req_a;
  logic [NREQ*vedic_arb_pkg::MUL_W-1:0] req_b;
  logic [NREQ-1:0]                      req_ready;
  logic                                 rsp_valid;
  logic                                 rsp_ready;
  logic [IDW-1:0]                       rsp_id;
  vedic_arb_pkg::ans_t                  rsp_ans;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_ans
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_ans
  );

endinterface

// File: rtl/vedic_maths2.sv
// 3x3 unsigned Urdhva-Tiryakbhyam (vertical and crosswise) multiplier, purely combinational.
module vedic_maths2
  import vedic_arb_pkg::*;
(
  input  operand_t a,
  input  operand_t b,
  output ans_t     ans
);

  logic [1:0] col1_s;
  logic [2:0] col2_s;
  logic [2:0] col3_s;
  logic [1:0] col4_s;

  // Column sums of the crosswise partial products, each absorbing the previous column's carry
  always_comb begin
    col1_s = {1'b0, a[1] & b[0]} + {1'b0, a[0] & b[1]};
    col2_s = {2'b00, a[2] & b[0]} + {2'b00, a[1] & b[1]} + {2'b00, a[0] & b[2]}
           + {2'b00, col1_s[1]};
    col3_s = {2'b00, a[2] & b[1]} + {2'b00, a[1] & b[2]} + {1'b0, col2_s[2:1]};
    col4_s = {1'b0, a[2] & b[2]} + col3_s[2:1];
    ans    = {col4_s, col3_s[0], col2_s[0], col1_s[0], a[0] & b[0]};
  end

endmodule

// File: rtl/vedic_rr_picker.sv
// Round-robin search of req_valid starting at rr_ptr; returns one-hot grant and its index.
module vedic_rr_picker #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            found
);

  logic [IDW-1:0]  cand_s;
  logic [NREQ-1:0] rot_s;

  // First valid requester at or after rr_ptr, wrapping NREQ-1 -> 0
  always_comb begin
    grant_idx = {IDW{1'b0}};
    found     = 1'b0;
    cand_s    = {IDW{1'b0}};
    rot_s     = {NREQ{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      cand_s = IDW'((int'(rr_ptr) + i) % NREQ);
      rot_s  = req_valid >> cand_s;
      if (!found && rot_s[0]) begin
        found     = 1'b1;
        grant_idx = cand_s;
      end else begin
        found     = found;
      end
    end
    if (found) begin
      grant = {{(NREQ-1){1'b0}}, 1'b1} << grant_idx;
    end else begin
      grant = {NREQ{1'b0}};
    end
  end

endmodule

// File: rtl/vedic_mul_arbiter.sv
// Shares one vedic_maths2 multiplier among NREQ requesters with round-robin grant and a
// registered, id-tagged response slot. Define VEDIC_ARB_STATS_EN for stat_ops/stat_stall.
module vedic_mul_arbiter
  import vedic_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef VEDIC_ARB_STATS_EN
  output logic [15:0] stat_ops,
  output logic [15:0] stat_stall,
`endif
  vedic_mul_arbiter_if.slave bus
);

  state_t          state_r;
  state_t          state_nx_s;
  logic [IDW-1:0]  rr_ptr_r;
  logic [IDW-1:0]  rsp_id_r;
  ans_t            rsp_ans_r;
  logic            rsp_valid_r;
  logic [NREQ-1:0] grant_s;
  logic [IDW-1:0]  grant_idx_s;
  logic            found_s;
  logic            can_take_s;
  logic            accept_s;
  operand_t        mul_a_s;
  operand_t        mul_b_s;
  ans_t            mul_ans_s;

  vedic_rr_picker #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_picker (
    .req_valid (bus.req_valid),
    .rr_ptr    (rr_ptr_r),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .found     (found_s)
  );

  // Operand mux feeding the single multiplier from the granted requester
  always_comb begin
    mul_a_s = operand_t'(bus.req_a >> (MUL_W * int'(grant_idx_s)));
    mul_b_s = operand_t'(bus.req_b >> (MUL_W * int'(grant_idx_s)));
  end

  vedic_maths2 u_mul (
    .a   (mul_a_s),
    .b   (mul_b_s),
    .ans (mul_ans_s)
  );

  // Slot FSM: a FULL slot that drains this cycle can be refilled on the same edge.
  // Nothing is accepted while reset is asserted.
  always_comb begin
    state_nx_s = state_r;
    can_take_s = (state_r == EMPTY) | bus.rsp_ready;
    accept_s   = found_s & can_take_s & rst_n;
    case (state_r)
      EMPTY: begin
        if (accept_s) begin
          state_nx_s = FULL;
        end else begin
          state_nx_s = EMPTY;
        end
      end
      FULL: begin
        if (accept_s) begin
          state_nx_s = FULL;
        end else if (bus.rsp_ready) begin
          state_nx_s = EMPTY;
        end else begin
          state_nx_s = FULL;
        end
      end
      default: state_nx_s = EMPTY;
    endcase
  end

  assign bus.req_ready = accept_s ? grant_s : {NREQ{1'b0}};
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_id    = rsp_id_r;
  assign bus.rsp_ans   = rsp_ans_r;

  // State, response register and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= EMPTY;
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= {IDW{1'b0}};
      rsp_ans_r   <= {ANS_W{1'b0}};
      rr_ptr_r    <= {IDW{1'b0}};
    end else begin
      state_r     <= state_nx_s;
      rsp_valid_r <= (state_nx_s == FULL);
      if (accept_s) begin
        rsp_ans_r <= mul_ans_s;
        rsp_id_r  <= grant_idx_s;
        rr_ptr_r  <= (grant_idx_s == IDW'(NREQ - 1)) ? {IDW{1'b0}} : grant_idx_s + IDW'(1);
      end
    end
  end

`ifdef VEDIC_ARB_STATS_EN
  // Saturating delivery and stall counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops   <= 16'h0000;
      stat_stall <= 16'h0000;
    end else begin
      if (rsp_valid_r && bus.rsp_ready && (stat_ops != 16'hFFFF)) begin
        stat_ops <= stat_ops + 16'h0001;
      end
      if (rsp_valid_r && !bus.rsp_ready && (stat_stall != 16'hFFFF)) begin
        stat_stall <= stat_stall + 16'h0001;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vedic_mul_arbiter.sv
// Randomized and directed bench for vedic_mul_arbiter against a behavioural slot/arbiter model.
module tb_vedic_mul_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clk;
  logic rst_n;
`ifdef VEDIC_ARB_STATS_EN
  logic [15:0] stat_ops;
  logic [15:0] stat_stall;
`endif

  vedic_mul_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  vedic_mul_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef VEDIC_ARB_STATS_EN
    .stat_ops   (stat_ops),
    .stat_stall (stat_stall),
`endif
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  // requester-side stimulus state
  bit       v_q[NREQ];
  logic [2:0] a_q[NREQ];
  logic [2:0] b_q[NREQ];
  bit       rsp_rdy_q;
  logic [NREQ-1:0] last_ready;

  // reference model
  int m_ptr, m_id, m_ans, m_ops, m_stall;
  bit m_full;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    for (int r = 0; r < NREQ; r++) begin
      bus.req_valid[r]      = v_q[r];
      bus.req_a[3*r +: 3]   = a_q[r];
      bus.req_b[3*r +: 3]   = b_q[r];
    end
    bus.rsp_ready = rsp_rdy_q;
  endtask

  task automatic model_reset();
    m_ptr = 0; m_id = 0; m_ans = 0; m_full = 1'b0; m_ops = 0; m_stall = 0;
  endtask

  // one clock: check combinational grant, step the model, check registered outputs
  task automatic cycle();
    int g;
    bit take;
    logic [NREQ-1:0] exp_ready;
    drive();
    #1;
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      if (g < 0 && v_q[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
    end
    take = (g >= 0) && (!m_full || rsp_rdy_q);
    exp_ready = take ? NREQ'(1 << g) : '0;
    last_ready = bus.req_ready;
    check_eq("req_ready", bus.req_ready, exp_ready);
    @(posedge clk);
    #1;
    if (m_full && rsp_rdy_q && m_ops < 65535) m_ops++;
    if (m_full && !rsp_rdy_q && m_stall < 65535) m_stall++;
    if (take) begin
      m_ans  = a_q[g] * b_q[g];
      m_id   = g;
      m_full = 1'b1;
      m_ptr  = (g + 1) % NREQ;
      v_q[g] = 1'b0;
    end else if (m_full && rsp_rdy_q) begin
      m_full = 1'b0;
    end
    check_eq("rsp_valid", bus.rsp_valid, m_full);
    check_eq("rsp_id", bus.rsp_id, m_id);
    check_eq("rsp_ans", bus.rsp_ans, m_ans);
`ifdef VEDIC_ARB_STATS_EN
    check_eq("stat_ops", stat_ops, m_ops);
    check_eq("stat_stall", stat_stall, m_stall);
`endif
  endtask

  task automatic do_reset();
    for (int r = 0; r < NREQ; r++) v_q[r] = 1'b1;
    drive();
    rst_n = 1'b0;
    #1;
    check_eq("rst_valid", bus.rsp_valid, 0);
    check_eq("rst_ans", bus.rsp_ans, 0);
    check_eq("rst_id", bus.rsp_id, 0);
    check_eq("rst_ready", bus.req_ready, 0);
    @(posedge clk);
    #1;
    check_eq("rst_ready_edge", bus.req_ready, 0);
    check_eq("rst_valid_edge", bus.rsp_valid, 0);
    for (int r = 0; r < NREQ; r++) v_q[r] = 1'b0;
    drive();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    rst_n     = 1'b1;
    rsp_rdy_q = 1'b0;
    for (int r = 0; r < NREQ; r++) begin
      v_q[r] = 1'b0; a_q[r] = 3'd0; b_q[r] = 3'd0;
    end
    drive();
    #2;
    do_reset();

    // single requester
    v_q[1] = 1'b1; a_q[1] = 3'd5; b_q[1] = 3'd6; rsp_rdy_q = 1'b1;
    cycle();
    check_eq("single_ready", last_ready, 4'b0010);
    check_eq("single_ans", bus.rsp_ans, 30);
    check_eq("single_id", bus.rsp_id, 1);

    // round robin with all requesters busy
    do_reset();
    rsp_rdy_q = 1'b1;
    for (int i = 0; i < 8; i++) begin
      for (int r = 0; r < NREQ; r++) begin
        v_q[r] = 1'b1; a_q[r] = 3'($urandom_range(0, 7)); b_q[r] = 3'($urandom_range(0, 7));
      end
      cycle();
      check_eq("rr_order", bus.rsp_id, i % NREQ);
    end

    // backpressure, then drain and refill on the same edge
    do_reset();
    v_q[0] = 1'b1; a_q[0] = 3'd7; b_q[0] = 3'd7; rsp_rdy_q = 1'b1;
    cycle();
    check_eq("bp_first", bus.rsp_ans, 49);
    v_q[2] = 1'b1; a_q[2] = 3'd3; b_q[2] = 3'd2; rsp_rdy_q = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("bp_hold_ans", bus.rsp_ans, 49);
      check_eq("bp_hold_ready", last_ready, 0);
    end
    rsp_rdy_q = 1'b1;
    cycle();
    check_eq("bp_refill_ready", last_ready, 4'b0100);
    check_eq("bp_refill_ans", bus.rsp_ans, 6);
    check_eq("bp_refill_id", bus.rsp_id, 2);

    // exhaustive operands on every requester
    rsp_rdy_q = 1'b1;
    for (int r = 0; r < NREQ; r++) begin
      for (int a = 0; a < 8; a++) begin
        for (int b = 0; b < 8; b++) begin
          v_q[r] = 1'b1; a_q[r] = 3'(a); b_q[r] = 3'(b);
          cycle();
          check_eq("exh_ans", bus.rsp_ans, a * b);
          check_eq("exh_id", bus.rsp_id, r);
        end
      end
    end

    // randomized traffic with backpressure and withdrawn requests
    for (int n = 0; n < 1500; n++) begin
      for (int r = 0; r < NREQ; r++) begin
        if (!v_q[r]) begin
          if ($urandom_range(0, 1) == 1) begin
            v_q[r] = 1'b1;
            a_q[r] = 3'($urandom_range(0, 7));
            b_q[r] = 3'($urandom_range(0, 7));
          end
        end else if ($urandom_range(0, 15) == 0) begin
          v_q[r] = 1'b0;
        end
      end
      rsp_rdy_q = ($urandom_range(0, 3) != 0);
      cycle();
    end

    // reset while a product is held
    for (int r = 0; r < NREQ; r++) v_q[r] = 1'b0;
    v_q[1] = 1'b1; a_q[1] = 3'd3; b_q[1] = 3'd4; rsp_rdy_q = 1'b1;
    cycle();
    rsp_rdy_q = 1'b0;
    cycle();
    check_eq("midrst_before", bus.rsp_ans, 12);
    do_reset();
    for (int r = 0; r < NREQ; r++) v_q[r] = 1'b1;
    rsp_rdy_q = 1'b1;
    cycle();
    check_eq("midrst_grant", last_ready, 4'b0001);
    check_eq("midrst_id", bus.rsp_id, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
